id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- RV32I instruction decode stage. Sits between the IF/ID pipeline register and the ID/EX pipeline register.
- Decodes all 37 RV32I instructions into the control bundle that ID/EX latches, and generates immediates.
- Contains the 32x32 register file, with a WB write port and same-cycle write-through bypass.
- Detects load-use hazards and drives stall/bubble requests.

Parameters:
- N, 32, data/address width
- NREGS, 32, register count (fixed; x0 hardwired zero)

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_valid  in  1  IF/ID holds a valid instruction
- i_instr  in  N  instruction word from IF/ID
- i_pc  in  N  PC of i_instr
- i_wb_en  in  1  writeback enable from WB stage
- i_wb_addr  in  5  writeback destination
- i_wb_data  in  N  writeback data
- i_ex_mem_read  in  1  instruction currently in EX is a load
- i_ex_rd_addr  in  5  rd of instruction in EX
- o_pc, o_rs1_data, o_rs2_data, o_immediate  out  N  to ID/EX
- o_rs1_addr, o_rs2_addr, o_rd_addr  out  5  to ID/EX
- o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_alu_a_sel, o_branch_en, o_jal, o_jalr  out  1  controls
- o_wb_sel, o_pc_sel  out  2  controls
- o_alu_ctrl  out  4  ALU op
- o_branch_type, o_mem_type  out  3  funct3 passthrough for branch/load/store, else 0
- o_stall  out  1  hold PC and IF/ID this cycle
- o_bubble  out  1  flush request to ID/EX (equals o_stall)
- o_illegal  out  1  undecodable opcode/funct

Behaviour:
- Reset: all 32 registers cleared to 0 asynchronously. Reads during and immediately after reset return 0.
- All decode outputs are combinational from current inputs. The only state is the register file.
- Register write: at posedge, when i_wb_en=1 and i_wb_addr!=0. Writes to x0 are ignored; x0 always reads 0.
- Register read is combinational, with bypass: if i_wb_en and i_wb_addr==rsX_addr!=0, o_rsX_data=i_wb_data (same-cycle write visible).
- Register-source address rules:
  - rs1 addr = instr[19:15] for R/I/S/B/JALR types, else 0.
  - rs2 addr = instr[24:20] for R/S/B, else 0.
  - Unused rsX outputs data 0.
- rd addr = instr[11:7] when reg_write=1, else 0.
- Immediates, sign-extended to N:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type: 0
- alu_ctrl: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B (LUI). Loads, stores, AUIPC, JAL and JALR use ADD.
- alu_src=1 for I/S/U/J types. alu_a_sel=1 (PC) for AUIPC and JAL.
- wb_sel: 0 ALU, 1 MEM (loads), 2 PC+4 (JAL/JALR).
- pc_sel: 0 sequential, 1 branch/JAL target, 2 JALR target.
- branch_en=1 for BEQ..BGEU. jal/jalr flags per opcode.
- Illegal decode:
  - Triggers on an unknown opcode, an invalid funct3/funct7 (e.g. funct7 not 0000000/0100000 where meaningful), or BRANCH funct3 010/011.
  - Response: all control outputs 0 (NOP), o_illegal=1.
- FENCE/ECALL/EBREAK decode as NOP with o_illegal=0.
- i_valid=0: all control outputs 0, o_illegal=0, o_stall=0. Data outputs are don't-care but must be deterministic.
- Load-use hazard:
  - o_stall = i_valid & i_ex_mem_read & i_ex_rd_addr!=0 & (i_ex_rd_addr==rs1_addr | i_ex_rd_addr==rs2_addr), using the gated addresses above.
  - When o_stall=1, controls are still driven normally; the ID/EX flush and IF/ID hold are upstream's duty.
- Simultaneous write and read of the same register: bypass wins. Write and hazard in the same cycle are independent.
- Reset mid-operation: register contents lost (all 0). Outputs follow the new decode immediately.

Test Plan:
- Reset → read x1..x31 via R-type ADD x3,x1,x2 → o_rs1_data=o_rs2_data=0, o_alu_ctrl=0, o_reg_write=1, o_rd_addr=3.
- WB write x5=0xDEADBEEF at cycle n; decode ADDI x6,x5,-1 (0xFFF28313) in cycle n → bypass o_rs1_data=0xDEADBEEF, o_immediate=0xFFFFFFFF, o_alu_src=1. Cycle n+1 reads the same value from the array.
- WB write to x0 with 0x1234 → later read of x0 returns 0.
- i_ex_mem_read=1, i_ex_rd_addr=5, instr ADD x7,x5,x8 → o_stall=o_bubble=1. Same with i_ex_rd_addr=0 or LUI x7 → o_stall=0.
- BEQ x1,x2,-8 (0xFE208CE3) → o_immediate=0xFFFFFFF8, branch_en=1, branch_type=0, pc_sel=1, reg_write=0, rd_addr=0. JAL x1,+2048 → immediate=0x800, wb_sel=2, alu_a_sel=1.
- Opcode 0x7F, or SUB with funct7=0x01 → o_illegal=1, all controls 0. i_valid=0 → controls 0, o_stall=0.

Source files
------------

// File: rtl/id_stage.sv
// RV32I decode stage: control/immediate decode, 32x32 register file with
// write-through bypass, and load-use hazard detection.
module id_stage #(
  parameter int N     = 32,
  parameter int NREGS = 32
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  input  logic         i_valid,
  input  logic [N-1:0] i_instr,
  input  logic [N-1:0] i_pc,
  input  logic         i_wb_en,
  input  logic [4:0]   i_wb_addr,
  input  logic [N-1:0] i_wb_data,
  input  logic         i_ex_mem_read,
  input  logic [4:0]   i_ex_rd_addr,
  output logic [N-1:0] o_pc,
  output logic [N-1:0] o_rs1_data,
  output logic [N-1:0] o_rs2_data,
  output logic [N-1:0] o_immediate,
  output logic [4:0]   o_rs1_addr,
  output logic [4:0]   o_rs2_addr,
  output logic [4:0]   o_rd_addr,
  output logic         o_reg_write,
  output logic         o_mem_read,
  output logic         o_mem_write,
  output logic         o_alu_src,
  output logic         o_alu_a_sel,
  output logic         o_branch_en,
  output logic         o_jal,
  output logic         o_jalr,
  output logic [1:0]   o_wb_sel,
  output logic [1:0]   o_pc_sel,
  output logic [3:0]   o_alu_ctrl,
  output logic [2:0]   o_branch_type,
  output logic [2:0]   o_mem_type,
  output logic         o_stall,
  output logic         o_bubble,
  output logic         o_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BRJ  = 2'd1;
  localparam logic [1:0] PC_JALR = 2'd2;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [N-1:0] gen_imm(input imm_sel_t sel, input logic [31:0] ins);
    logic signed [31:0] imm32;
    case (sel)
      IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm32 = {ins[31:12], 12'b0};
      IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return N'(imm32);
  endfunction

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign instr  = i_instr[31:0];
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic       legal;
  logic       use_rs1;
  logic       use_rs2;
  imm_sel_t   imm_sel;
  logic       rw;
  logic       mr;
  logic       mw;
  logic       asrc;
  logic       asel;
  logic       br;
  logic       jal;
  logic       jalr;
  logic [1:0] wb_sel;
  logic [1:0] pc_sel;
  logic [3:0] alu;
  logic [2:0] br_type;
  logic [2:0] mem_type;

  // Raw decode; everything is gated by validity/legality further down
  always_comb begin
    legal    = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm_sel  = IMM_NONE;
    rw       = 1'b0;
    mr       = 1'b0;
    mw       = 1'b0;
    asrc     = 1'b0;
    asel     = 1'b0;
    br       = 1'b0;
    jal      = 1'b0;
    jalr     = 1'b0;
    wb_sel   = WB_ALU;
    pc_sel   = PC_SEQ;
    alu      = ALU_ADD;
    br_type  = 3'd0;
    mem_type = 3'd0;
    case (opcode)
      OP_LUI: begin
        legal   = 1'b1;
        rw      = 1'b1;
        asrc    = 1'b1;
        alu     = ALU_PASS_B;
        imm_sel = IMM_U;
      end
      OP_AUIPC: begin
        legal   = 1'b1;
        rw      = 1'b1;
        asrc    = 1'b1;
        asel    = 1'b1;
        imm_sel = IMM_U;
      end
      OP_JAL: begin
        legal   = 1'b1;
        rw      = 1'b1;
        asrc    = 1'b1;
        asel    = 1'b1;
        jal     = 1'b1;
        wb_sel  = WB_PC4;
        pc_sel  = PC_BRJ;
        imm_sel = IMM_J;
      end
      OP_JALR: begin
        legal   = (funct3 == 3'b000);
        rw      = 1'b1;
        asrc    = 1'b1;
        jalr    = 1'b1;
        wb_sel  = WB_PC4;
        pc_sel  = PC_JALR;
        use_rs1 = 1'b1;
        imm_sel = IMM_I;
      end
      OP_BRANCH: begin
        legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
        br      = 1'b1;
        pc_sel  = PC_BRJ;
        alu     = ALU_SUB;
        br_type = funct3;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_sel = IMM_B;
      end
      OP_LOAD: begin
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        rw       = 1'b1;
        mr       = 1'b1;
        asrc     = 1'b1;
        wb_sel   = WB_MEM;
        mem_type = funct3;
        use_rs1  = 1'b1;
        imm_sel  = IMM_I;
      end
      OP_STORE: begin
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        mw       = 1'b1;
        asrc     = 1'b1;
        mem_type = funct3;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        imm_sel  = IMM_S;
      end
      OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
        rw      = 1'b1;
        asrc    = 1'b1;
        alu     = alu_op(funct3, funct7[5] && (funct3 == 3'b101));
        use_rs1 = 1'b1;
        imm_sel = IMM_I;
      end
      OP_REG: begin
        legal   = (funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        rw      = 1'b1;
        alu     = alu_op(funct3, funct7[5]);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      // FENCE, ECALL and EBREAK are architectural no-ops in this pipeline
      OP_FENCE:  legal = (funct3 == 3'b000);
      OP_SYSTEM: legal = (instr[31:7] == 25'h0) || (instr[31:7] == 25'h0002000);
      default:   legal = 1'b0;
    endcase
  end

  logic dec_ok;
  assign dec_ok = i_valid && legal;

  assign o_illegal     = i_valid && !legal;
  assign o_reg_write   = dec_ok && rw;
  assign o_mem_read    = dec_ok && mr;
  assign o_mem_write   = dec_ok && mw;
  assign o_alu_src     = dec_ok && asrc;
  assign o_alu_a_sel   = dec_ok && asel;
  assign o_branch_en   = dec_ok && br;
  assign o_jal         = dec_ok && jal;
  assign o_jalr        = dec_ok && jalr;
  assign o_wb_sel      = dec_ok ? wb_sel   : WB_ALU;
  assign o_pc_sel      = dec_ok ? pc_sel   : PC_SEQ;
  assign o_alu_ctrl    = dec_ok ? alu      : ALU_ADD;
  assign o_branch_type = dec_ok ? br_type  : 3'd0;
  assign o_mem_type    = dec_ok ? mem_type : 3'd0;
  assign o_immediate   = dec_ok ? gen_imm(imm_sel, instr) : '0;
  assign o_pc          = i_pc;

  assign o_rs1_addr = (dec_ok && use_rs1) ? instr[19:15] : 5'd0;
  assign o_rs2_addr = (dec_ok && use_rs2) ? instr[24:20] : 5'd0;
  assign o_rd_addr  = o_reg_write ? instr[11:7] : 5'd0;

  logic [N-1:0] regs_q [NREGS];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
      regs_q[i_wb_addr] <= i_wb_data;
    end
  end

  // x0 reads zero; a same-cycle writeback to the read address wins over the array
  assign o_rs1_data = (o_rs1_addr == 5'd0) ? '0 :
                      (i_wb_en && (i_wb_addr == o_rs1_addr)) ? i_wb_data : regs_q[o_rs1_addr];
  assign o_rs2_data = (o_rs2_addr == 5'd0) ? '0 :
                      (i_wb_en && (i_wb_addr == o_rs2_addr)) ? i_wb_data : regs_q[o_rs2_addr];

  assign o_stall  = i_valid && i_ex_mem_read && (i_ex_rd_addr != 5'd0) &&
                    ((i_ex_rd_addr == o_rs1_addr) || (i_ex_rd_addr == o_rs2_addr));
  assign o_bubble = o_stall;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected decode results are queued as each
// vector is driven and compared on the following falling edge.
module tb_id_stage;

  logic        i_clk = 1'b0;
  logic        i_arst_n;
  logic        i_valid;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_ex_mem_read;
  logic [4:0]  i_ex_rd_addr;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_immediate;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic        o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_alu_a_sel;
  logic        o_branch_en, o_jal, o_jalr;
  logic [1:0]  o_wb_sel, o_pc_sel;
  logic [3:0]  o_alu_ctrl;
  logic [2:0]  o_branch_type, o_mem_type;
  logic        o_stall, o_bubble, o_illegal;

  always #5 i_clk = ~i_clk;

  id_stage #(.N(32), .NREGS(32)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_valid(i_valid), .i_instr(i_instr),
    .i_pc(i_pc), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rd_addr(i_ex_rd_addr),
    .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_immediate(o_immediate), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_alu_src(o_alu_src), .o_alu_a_sel(o_alu_a_sel),
    .o_branch_en(o_branch_en), .o_jal(o_jal), .o_jalr(o_jalr), .o_wb_sel(o_wb_sel),
    .o_pc_sel(o_pc_sel), .o_alu_ctrl(o_alu_ctrl), .o_branch_type(o_branch_type),
    .o_mem_type(o_mem_type), .o_stall(o_stall), .o_bubble(o_bubble),
    .o_illegal(o_illegal)
  );

  typedef struct {
    string       tag;
    bit          chk_data;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [21:0] ctrl;
    logic        stall;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc_next  = 32'h0000_1000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Control bundle order: rw,mr,mw,alu_src,alu_a_sel,br,jal,jalr,wb_sel,pc_sel,alu,br_type,mem_type
  function automatic logic [21:0] ctl(input bit rw, input bit mr, input bit mw, input bit as,
                                      input bit aa, input bit be, input bit j, input bit jr,
                                      input logic [1:0] wb, input logic [1:0] pc,
                                      input logic [3:0] alu, input logic [2:0] bt,
                                      input logic [2:0] mt);
    return {rw, mr, mw, as, aa, be, j, jr, wb, pc, alu, bt, mt};
  endfunction

  function automatic exp_t mk(input string tag, input bit chk, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] imm,
                              input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                              input logic [21:0] c, input logic st, input logic il);
    exp_t e;
    e.tag = tag; e.chk_data = chk; e.pc = '0;
    e.rs1_data = d1; e.rs2_data = d2; e.imm = imm;
    e.rs1a = a1; e.rs2a = a2; e.rda = ad; e.ctrl = c; e.stall = st; e.illegal = il;
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, input bit valid, input bit rst,
                       input bit wb_en, input logic [4:0] wb_addr, input logic [31:0] wb_data,
                       input bit exmr, input logic [4:0] exrd, input exp_t e);
    @(posedge i_clk);
    #1;
    i_arst_n      = !rst;
    i_valid       = valid;
    i_instr       = instr;
    i_pc          = pc_next;
    i_wb_en       = wb_en;
    i_wb_addr     = wb_addr;
    i_wb_data     = wb_data;
    i_ex_mem_read = exmr;
    i_ex_rd_addr  = exrd;
    e.pc          = pc_next;
    pc_next       = pc_next + 32'd4;
    sb.push_back(e);
  endtask

  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".ctrl"}, 32'({o_reg_write, o_mem_read, o_mem_write, o_alu_src,
                o_alu_a_sel, o_branch_en, o_jal, o_jalr, o_wb_sel, o_pc_sel, o_alu_ctrl,
                o_branch_type, o_mem_type}), 32'(e.ctrl));
      check_eq({e.tag, ".rd"}, 32'(o_rd_addr), 32'(e.rda));
      check_eq({e.tag, ".illegal"}, 32'(o_illegal), 32'(e.illegal));
      check_eq({e.tag, ".stall"}, 32'(o_stall), 32'(e.stall));
      check_eq({e.tag, ".bubble"}, 32'(o_bubble), 32'(e.stall));
      check_eq({e.tag, ".pc"}, o_pc, e.pc);
      if (e.chk_data) begin
        check_eq({e.tag, ".rs1a"}, 32'(o_rs1_addr), 32'(e.rs1a));
        check_eq({e.tag, ".rs2a"}, 32'(o_rs2_addr), 32'(e.rs2a));
        check_eq({e.tag, ".rs1d"}, o_rs1_data, e.rs1_data);
        check_eq({e.tag, ".rs2d"}, o_rs2_data, e.rs2_data);
        check_eq({e.tag, ".imm"}, o_immediate, e.imm);
      end
    end
  end

  localparam logic [31:0] I_ADD3  = 32'h002081B3;
  localparam logic [31:0] I_ADDI  = 32'hFFF28313;
  localparam logic [31:0] I_ADDX0 = 32'h00100313;
  localparam logic [31:0] I_ADD7  = 32'h008283B3;
  localparam logic [31:0] X1      = 32'h11111111;
  localparam logic [31:0] X2      = 32'h22222222;
  localparam logic [31:0] X5      = 32'hDEADBEEF;

  initial begin
    logic [21:0] c_add, c_addi, c_lui, c_beq, c_bge, c_jal, c_lw, c_sw;
    logic [21:0] c_sub, c_srai, c_auipc, c_jalr;
    c_add   = ctl(1,0,0,0,0,0,0,0, 2'd0, 2'd0, 4'd0,  3'd0, 3'd0);
    c_addi  = ctl(1,0,0,1,0,0,0,0, 2'd0, 2'd0, 4'd0,  3'd0, 3'd0);
    c_lui   = ctl(1,0,0,1,0,0,0,0, 2'd0, 2'd0, 4'd10, 3'd0, 3'd0);
    c_beq   = ctl(0,0,0,0,0,1,0,0, 2'd0, 2'd1, 4'd1,  3'd0, 3'd0);
    c_bge   = ctl(0,0,0,0,0,1,0,0, 2'd0, 2'd1, 4'd1,  3'd5, 3'd0);
    c_jal   = ctl(1,0,0,1,1,0,1,0, 2'd2, 2'd1, 4'd0,  3'd0, 3'd0);
    c_lw    = ctl(1,1,0,1,0,0,0,0, 2'd1, 2'd0, 4'd0,  3'd0, 3'd2);
    c_sw    = ctl(0,0,1,1,0,0,0,0, 2'd0, 2'd0, 4'd0,  3'd0, 3'd2);
    c_sub   = ctl(1,0,0,0,0,0,0,0, 2'd0, 2'd0, 4'd1,  3'd0, 3'd0);
    c_srai  = ctl(1,0,0,1,0,0,0,0, 2'd0, 2'd0, 4'd7,  3'd0, 3'd0);
    c_auipc = ctl(1,0,0,1,1,0,0,0, 2'd0, 2'd0, 4'd0,  3'd0, 3'd0);
    c_jalr  = ctl(1,0,0,1,0,0,0,1, 2'd2, 2'd2, 4'd0,  3'd0, 3'd0);

    i_arst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0;
    i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_ex_mem_read = 1'b0; i_ex_rd_addr = '0;

    // reset reads, then register writes seen through the bypass and the array
    drive(I_ADD3, 1, 1, 0, 0, 0, 0, 0, mk("rst_read", 1, 0, 0, 0, 1, 2, 3, c_add, 0, 0));
    drive(I_ADD3, 1, 0, 1, 1, X1, 0, 0, mk("byp_rs1", 1, X1, 0, 0, 1, 2, 3, c_add, 0, 0));
    drive(I_ADD3, 1, 0, 1, 2, X2, 0, 0, mk("byp_rs2", 1, X1, X2, 0, 1, 2, 3, c_add, 0, 0));
    drive(I_ADDI, 1, 0, 1, 5, X5, 0, 0, mk("addi_byp", 1, X5, 0, 32'hFFFFFFFF, 5, 0, 6, c_addi, 0, 0));
    drive(I_ADDI, 1, 0, 0, 0, 0, 0, 0, mk("addi_arr", 1, X5, 0, 32'hFFFFFFFF, 5, 0, 6, c_addi, 0, 0));
    drive(I_ADDX0, 1, 0, 1, 0, 32'h1234, 0, 0, mk("x0_wr", 1, 0, 0, 1, 0, 0, 6, c_addi, 0, 0));
    drive(I_ADDX0, 1, 0, 0, 0, 0, 0, 0, mk("x0_rd", 1, 0, 0, 1, 0, 0, 6, c_addi, 0, 0));

    // load-use hazard cases
    drive(I_ADD7, 1, 0, 0, 0, 0, 1, 5, mk("haz_rs1", 1, X5, 0, 0, 5, 8, 7, c_add, 1, 0));
    drive(I_ADD7, 1, 0, 1, 9, 32'h99, 1, 8, mk("haz_rs2_wb", 1, X5, 0, 0, 5, 8, 7, c_add, 1, 0));
    drive(I_ADD7, 1, 0, 0, 0, 0, 1, 0, mk("haz_rd0", 1, X5, 0, 0, 5, 8, 7, c_add, 0, 0));
    drive(I_ADD7, 1, 0, 0, 0, 0, 0, 5, mk("haz_noload", 1, X5, 0, 0, 5, 8, 7, c_add, 0, 0));
    drive(32'h123453B7, 1, 0, 0, 0, 0, 1, 8, mk("lui_nohaz", 1, 0, 0, 32'h12345000, 0, 0, 7, c_lui, 0, 0));

    // instruction formats
    drive(32'hFE208CE3, 1, 0, 0, 0, 0, 0, 0, mk("beq", 1, X1, X2, 32'hFFFFFFF8, 1, 2, 0, c_beq, 0, 0));
    drive(32'hFE20DCE3, 1, 0, 0, 0, 0, 0, 0, mk("bge", 1, X1, X2, 32'hFFFFFFF8, 1, 2, 0, c_bge, 0, 0));
    drive(32'h001000EF, 1, 0, 0, 0, 0, 0, 0, mk("jal", 1, 0, 0, 32'h800, 0, 0, 1, c_jal, 0, 0));
    drive(32'h00412503, 1, 0, 0, 0, 0, 0, 0, mk("lw", 1, X2, 0, 4, 2, 0, 10, c_lw, 0, 0));
    drive(32'hFE50AE23, 1, 0, 0, 0, 0, 0, 0, mk("sw", 1, X1, X5, 32'hFFFFFFFC, 1, 5, 0, c_sw, 0, 0));
    drive(32'h402081B3, 1, 0, 0, 0, 0, 0, 0, mk("sub", 1, X1, X2, 0, 1, 2, 3, c_sub, 0, 0));
    drive(32'h4030D213, 1, 0, 0, 0, 0, 0, 0, mk("srai", 1, X1, 0, 32'h403, 1, 0, 4, c_srai, 0, 0));
    drive(32'h00001497, 1, 0, 0, 0, 0, 0, 0, mk("auipc", 1, 0, 0, 32'h1000, 0, 0, 9, c_auipc, 0, 0));
    drive(32'h000280E7, 1, 0, 0, 0, 0, 0, 0, mk("jalr", 1, X5, 0, 0, 5, 0, 1, c_jalr, 0, 0));

    // illegal, invalid and no-op encodings
    drive(32'h0000007F, 1, 0, 0, 0, 0, 0, 0, mk("ill_op", 0, 0, 0, 0, 0, 0, 0, 22'd0, 0, 1));
    drive(32'h022081B3, 1, 0, 0, 0, 0, 0, 0, mk("ill_f7", 0, 0, 0, 0, 0, 0, 0, 22'd0, 0, 1));
    drive(32'hFE20ACE3, 1, 0, 0, 0, 0, 0, 0, mk("ill_br", 0, 0, 0, 0, 0, 0, 0, 22'd0, 0, 1));
    drive(I_ADD7, 0, 0, 0, 0, 0, 1, 5, mk("invalid", 0, 0, 0, 0, 0, 0, 0, 22'd0, 0, 0));
    drive(32'h0000000F, 1, 0, 0, 0, 0, 0, 0, mk("fence", 0, 0, 0, 0, 0, 0, 0, 22'd0, 0, 0));
    drive(32'h00000073, 1, 0, 0, 0, 0, 0, 0, mk("ecall", 0, 0, 0, 0, 0, 0, 0, 22'd0, 0, 0));

    // reset in mid-operation wipes the register file
    drive(I_ADD7, 1, 1, 0, 0, 0, 0, 0, mk("rst_mid", 1, 0, 0, 0, 5, 8, 7, c_add, 0, 0));
    drive(I_ADDI, 1, 0, 0, 0, 0, 0, 0, mk("post_rst", 1, 0, 0, 32'hFFFFFFFF, 5, 0, 6, c_addi, 0, 0));

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge i_clk);
    #1;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
